// File: rtl/reg_file_multi.sv
// Multi-port register bank: DEPTH x WIDTH registers, one load/inc/dec write port,
// two registered read ports, zero flag of the last executed write. Macro REG_FILE_BYPASS_EN.
module reg_file_multi #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             wr_zero
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic             wr_zero_q, wr_zero_d;

    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_result;
    logic             wr_hit;
    logic             wr_en;

    // Address decode by loop so out-of-range and hardwired-zero addresses simply never hit.
    always_comb begin
        wr_cur = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
                wr_cur = regs_q[i];
                wr_hit = 1'b1;
            end
        end
    end

    assign wr_en = wr_hit && (wr_op != OP_HOLD);

    always_comb begin
        wr_result = wr_cur;
        case (wr_op)
            OP_LOAD: wr_result = wr_data;
            OP_INC:  wr_result = wr_cur + WIDTH'(1);
            OP_DEC:  wr_result = wr_cur - WIDTH'(1);
            default: wr_result = wr_cur;
        endcase
    end

    always_comb begin
        rd_a_d    = '0;
        rd_b_d    = '0;
        wr_zero_d = wr_zero_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                if (rd_addr_a == AW'(i)) rd_a_d = regs_q[i];
                if (rd_addr_b == AW'(i)) rd_b_d = regs_q[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && rd_addr_a == wr_addr) rd_a_d = wr_result;
        if (wr_en && rd_addr_b == wr_addr) rd_b_d = wr_result;
`endif
        if (wr_en) wr_zero_d = (wr_result == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_zero_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == AW'(i)) regs_q[i] <= wr_result;
            end
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            wr_zero_q <= wr_zero_d;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign wr_zero   = wr_zero_q;

endmodule

// File: tb/tb_reg_file_multi.sv
// Bench for reg_file_multi: default instance plus a ZERO_REG=1, DEPTH=6 instance on shared inputs,
// checked against an array-based reference model.
module tb_reg_file_multi;

    localparam int W = 16;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   wr_op = 2'b00;
    logic [2:0]   wr_addr = 3'd0;
    logic [W-1:0] wr_data = '0;
    logic [2:0]   rd_addr_a = 3'd0;
    logic [2:0]   rd_addr_b = 3'd0;
    logic [W-1:0] a0, b0, a1, b1;
    logic         z0, z1;

    reg_file_multi #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a0), .rd_data_b(b0), .wr_zero(z0)
    );

    reg_file_multi #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a1), .rd_data_b(b1), .wr_zero(z1)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: two register banks described by depth and zero-register flag
    int           depth_of [2] = '{8, 6};
    bit           zreg_of  [2] = '{1'b0, 1'b1};
    logic [W-1:0] mem  [2][8];
    logic         zflg [2];
    logic [W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_read(input int k, input int addr);
        if (addr >= depth_of[k] || (zreg_of[k] && addr == 0)) return '0;
        return mem[k][addr];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = '0;
            zflg[k] = 1'b0;
        end
    endtask

    // one clock cycle: apply inputs, predict, clock, compare all six outputs
    task automatic step(input logic [1:0] op, input int wa, input logic [W-1:0] wd,
                        input int ra, input int rb, input string tag);
        int cur, nv, ea, eb;
        bit exec;
        wr_op = op; wr_addr = 3'(wa); wr_data = wd; rd_addr_a = 3'(ra); rd_addr_b = 3'(rb);
        for (int k = 0; k < 2; k++) begin
            ea = int'(ref_read(k, ra));
            eb = int'(ref_read(k, rb));
            exec = (op != 2'b00) && (wa < depth_of[k]) && !(zreg_of[k] && wa == 0);
            if (exec) begin
                cur = int'(mem[k][wa]);
                if (op == 2'b01)      nv = int'(wd);
                else if (op == 2'b10) nv = (cur + 1) % 65536;
                else                  nv = (cur + 65535) % 65536;
                if (BYP && ra == wa) ea = nv;
                if (BYP && rb == wa) eb = nv;
                mem[k][wa] = W'(nv);
                zflg[k] = (nv == 0);
            end
            exp_q.push_back(W'(ea));
            exp_q.push_back(W'(eb));
            exp_q.push_back(W'(zflg[k]));
        end
        @(posedge clk);
        #1;
        chk({tag, ".a0"}, a0, exp_q.pop_front());
        chk({tag, ".b0"}, b0, exp_q.pop_front());
        chk({tag, ".z0"}, W'(z0), exp_q.pop_front());
        chk({tag, ".a1"}, a1, exp_q.pop_front());
        chk({tag, ".b1"}, b1, exp_q.pop_front());
        chk({tag, ".z1"}, W'(z1), exp_q.pop_front());
    endtask

    // asynchronous reset pulse between clock edges; outputs must clear before any edge
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".a0"}, a0, '0);
        chk({tag, ".b0"}, b0, '0);
        chk({tag, ".z0"}, W'(z0), '0);
        chk({tag, ".a1"}, a1, '0);
        chk({tag, ".z1"}, W'(z1), '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_a0", a0, '0);
        chk("rst_b0", b0, '0);
        chk("rst_z0", W'(z0), '0);
        @(negedge clk);
        rst = 1'b1;

        // reset clears prior contents
        step(2'b01, 3, 16'hAAAA, 3, 3, "ld_r3");
        step(2'b00, 0, 16'h0000, 3, 3, "rd_r3");
        async_reset("arst1");
        step(2'b00, 0, 16'h0000, 3, 3, "rd_r3_after_rst");

        // load/read, hold with junk data
        step(2'b01, 2, 16'hBBBB, 0, 0, "ld_r2");
        step(2'b00, 2, 16'hFFFF, 2, 2, "hold_rd_r2");
        step(2'b00, 0, 16'h0000, 2, 2, "rd_r2_again");

        // wrap around in both directions
        step(2'b01, 5, 16'hFFFF, 5, 4, "ld_r5");
        step(2'b10, 5, 16'h0000, 5, 5, "inc_r5");
        step(2'b11, 5, 16'h0000, 5, 5, "dec_r5");
        step(2'b00, 0, 16'h0000, 5, 5, "rd_r5");

        // read-during-write on the same address
        step(2'b01, 1, 16'h1234, 0, 0, "ld_r1");
        step(2'b01, 1, 16'h5678, 1, 1, "rdw_r1");
        step(2'b00, 0, 16'h0000, 1, 1, "rd_r1");

        // zero register and out-of-range writes on the DEPTH=6 instance
        step(2'b01, 0, 16'hFFFF, 0, 0, "ld_r0");
        step(2'b00, 0, 16'h0000, 0, 0, "rd_r0");
        step(2'b01, 6, 16'h0000, 6, 7, "ld_r6");
        step(2'b11, 7, 16'h0000, 7, 6, "dec_r7");
        step(2'b00, 0, 16'h0000, 6, 7, "rd_r6_r7");

        // increment stream interrupted by asynchronous reset
        step(2'b01, 4, 16'h0005, 4, 4, "ld_r4");
        step(2'b10, 4, 16'h0000, 4, 4, "inc_r4_a");
        step(2'b10, 4, 16'h0000, 4, 4, "inc_r4_b");
        step(2'b00, 4, 16'h0000, 4, 4, "rd_r4_7");
        async_reset("arst2");
        step(2'b10, 4, 16'h0000, 4, 4, "inc_r4_post");
        step(2'b00, 0, 16'h0000, 4, 4, "rd_r4_1");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] d;
            int sel;
            sel = int'($urandom_range(0, 3));
            d = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : W'($urandom);
            step(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), d,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
